// File: rtl/rr_cnt_sched.sv
// rr_cnt_sched: three-way round-robin owner of a shared counter with bounded tenure and a one-cycle gap.
module rr_cnt_sched #(
    parameter int MAX_HOLD = 4,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    output logic [2:0]       gnt,
    output logic [CNT_W-1:0] cnt,
    output logic             busy
);
    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] MAX_HCNT = HW'(MAX_HOLD);

    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

    state_t           state_q, state_d;
    logic [2:0]       gnt_q, gnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [HW-1:0]    hcnt_q, hcnt_d;
    logic [2:0]       r, s;
    logic [1:0]       sel;
    logic             own;

    function automatic logic [1:0] inc3(input logic [1:0] p);
        return p == 2'd2 ? 2'd0 : p + 2'd1;
    endfunction

    always_comb begin
        r       = {c, b, a};
        // s[k] is the request of requester (ptr+k) mod 3
        s       = ptr_q == 2'd0 ? r : ptr_q == 2'd1 ? {r[0], r[2:1]} : {r[1:0], r[2]};
        sel     = s[0] ? ptr_q : s[1] ? inc3(ptr_q) : inc3(inc3(ptr_q));
        own     = |(gnt_q & r);
        state_d = state_q;
        gnt_d   = gnt_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        hcnt_d  = hcnt_q;
        if (state_q == GRANT) begin
            if (own) begin
                cnt_d  = cnt_q + CNT_W'(1);
                hcnt_d = hcnt_q + HW'(1);
                if (hcnt_d == MAX_HCNT) begin
                    state_d = GAP;
                    gnt_d   = 3'b000;
                end
            end else begin
                state_d = GAP;
                gnt_d   = 3'b000;
            end
        end else if (|r) begin
            state_d = GRANT;
            gnt_d   = 3'b001 << sel;
            hcnt_d  = '0;
            ptr_d   = inc3(sel);
        end else begin
            state_d = IDLE;
            gnt_d   = 3'b000;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= 3'b000;
            cnt_q   <= '0;
            ptr_q   <= 2'd0;
            hcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            hcnt_q  <= hcnt_d;
        end
    end

    assign gnt  = gnt_q;
    assign cnt  = cnt_q;
    assign busy = |gnt_q;
endmodule

// File: tb/tb_rr_cnt_sched.sv
// tb_rr_cnt_sched: directed scenario tests for rr_cnt_sched with MAX_HOLD=4, CNT_W=8.
module tb_rr_cnt_sched;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       a = 1'b0, b = 1'b0, c = 1'b0;
    logic [2:0] gnt;
    logic [7:0] cnt;
    logic       busy;
    int         errors = 0;
    int         checks = 0;

    rr_cnt_sched #(.MAX_HOLD(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c),
        .gnt(gnt), .cnt(cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        {a, b, c} = 3'b000;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        #2;
        checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL reset_gnt: got %b want 000", gnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", cnt); end
        rst_n = 1'b1;
        a = 1'b1;
        tick;
        checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL reset_first_gnt: got %b want 001", gnt); end
        tick;
        tick;
        checks++; if (cnt !== 8'd2) begin errors++; $display("FAIL reset_pre_cnt: got %0d want 2", cnt); end
        rst_n = 1'b0;
        #1;
        checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL reset_mid_gnt: got %b want 000", gnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_mid_busy: got %b want 0", busy); end
        checks++; if (cnt !== 8'd0) begin errors++; $display("FAIL reset_mid_cnt: got %0d want 0", cnt); end
        #1;
        rst_n = 1'b1;
        b = 1'b1;
        tick;
        checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL reset_release_gnt: got %b want 001", gnt); end
        checks++; if (cnt !== 8'd0) begin errors++; $display("FAIL reset_release_cnt: got %0d want 0", cnt); end
        do_reset;
    endtask

    task automatic test_single;
        logic [2:0] eg [10] = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b000,
                                3'b001, 3'b001, 3'b001, 3'b001, 3'b000};
        logic [7:0] ec [10] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        a = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick;
            checks++; if (gnt !== eg[i]) begin errors++; $display("FAIL single_gnt[%0d]: got %b want %b", i, gnt, eg[i]); end
            checks++; if (cnt !== ec[i]) begin errors++; $display("FAIL single_cnt[%0d]: got %0d want %0d", i, cnt, ec[i]); end
        end
        do_reset;
    endtask

    task automatic test_round_robin;
        logic [2:0] eg [16] = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b000,
                                3'b010, 3'b010, 3'b010, 3'b010, 3'b000,
                                3'b100, 3'b100, 3'b100, 3'b100, 3'b000, 3'b001};
        {a, b, c} = 3'b111;
        for (int i = 0; i < 16; i++) begin
            tick;
            checks++; if (gnt !== eg[i]) begin errors++; $display("FAIL rr_gnt[%0d]: got %b want %b", i, gnt, eg[i]); end
            checks++; if (busy !== (eg[i] != 3'b000)) begin errors++; $display("FAIL rr_busy[%0d]: got %b want %b", i, busy, eg[i] != 3'b000); end
            if (i == 14) begin
                checks++; if (cnt !== 8'd12) begin errors++; $display("FAIL rr_cnt: got %0d want 12", cnt); end
            end
        end
        do_reset;
    endtask

    task automatic test_early_release;
        b = 1'b1;
        tick;
        checks++; if (gnt !== 3'b010) begin errors++; $display("FAIL early_gnt: got %b want 010", gnt); end
        tick;
        tick;
        checks++; if (cnt !== 8'd2) begin errors++; $display("FAIL early_cnt2: got %0d want 2", cnt); end
        b = 1'b0;
        tick;
        checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL early_gap_gnt: got %b want 000", gnt); end
        checks++; if (cnt !== 8'd2) begin errors++; $display("FAIL early_gap_cnt: got %0d want 2", cnt); end
        tick;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL early_idle_busy: got %b want 0", busy); end
        {b, c} = 2'b11;
        tick;
        checks++; if (gnt !== 3'b100) begin errors++; $display("FAIL early_next_gnt: got %b want 100", gnt); end
        do_reset;
    endtask

    task automatic test_ignore_non_owner;
        a = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            c = i[0];
            tick;
            checks++; if (gnt !== (i == 5 ? 3'b000 : 3'b001)) begin errors++; $display("FAIL ignore_gnt[%0d]: got %b want %b", i, gnt, i == 5 ? 3'b000 : 3'b001); end
            checks++; if (cnt !== 8'(i - 1)) begin errors++; $display("FAIL ignore_cnt[%0d]: got %0d want %0d", i, cnt, i - 1); end
        end
        a = 1'b0;
        c = 1'b1;
        tick;
        checks++; if (gnt !== 3'b100) begin errors++; $display("FAIL ignore_c_gnt: got %b want 100", gnt); end
        checks++; if (cnt !== 8'd4) begin errors++; $display("FAIL ignore_c_cnt: got %0d want 4", cnt); end
        do_reset;
    endtask

    task automatic test_wrap;
        a = 1'b1;
        for (int k = 1; k <= 320; k++) begin
            tick;
            checks++; if (gnt !== (k % 5 == 0 ? 3'b000 : 3'b001)) begin errors++; $display("FAIL wrap_gnt[%0d]: got %b want %b", k, gnt, k % 5 == 0 ? 3'b000 : 3'b001); end
            if (k == 319) begin
                checks++; if (cnt !== 8'd255) begin errors++; $display("FAIL wrap_cnt255: got %0d want 255", cnt); end
            end
        end
        checks++; if (cnt !== 8'd0) begin errors++; $display("FAIL wrap_cnt0: got %0d want 0", cnt); end
        do_reset;
    endtask

    initial begin
        test_reset;
        test_single;
        test_round_robin;
        test_early_release;
        test_ignore_non_owner;
        test_wrap;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rr_cnt_sched.md
RR_CNT_SCHED -- requirements
Module: rr_cnt_sched

Interface
REQ-001 The block SHALL have parameter MAX_HOLD, default 4, meaning the maximum number of increments per grant tenure (legal range 1..15).
REQ-002 The block SHALL have parameter CNT_W, default 8, meaning the width of the shared counter.
REQ-003 Port clk  input  1  clock; all state SHALL change on posedge clk only.
REQ-004 Port rst_n  input  1  reset; asynchronous, active-low.
REQ-005 Port a  input  1  request from requester 0.
REQ-006 Port b  input  1  request from requester 1.
REQ-007 Port c  input  1  request from requester 2.
REQ-008 Port gnt  output  3  registered one-hot grant; bit0=a, bit1=b, bit2=c.
REQ-009 Port cnt  output  CNT_W  registered shared counter value.
REQ-010 Port busy  output  1  high while a grant is active (state GRANT).

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, GRANT and GAP.
REQ-012 The block SHALL hold a 2-bit round-robin pointer ptr in {0,1,2} and a hold counter hcnt of width ceil(log2(MAX_HOLD+1)).
REQ-013 In IDLE or GAP, if any of a/b/c is high at the edge, the block SHALL select the first high requester in order ptr, ptr+1, ptr+2 (mod 3), enter GRANT, set gnt to that one-hot value, clear hcnt to 0, and set ptr to (selected+1) mod 3.
REQ-014 In IDLE or GAP, if no request is high at the edge, the block SHALL go to IDLE with gnt=000.
REQ-015 The grant latency SHALL be one cycle: gnt is visible in the cycle after the edge that samples the request.
REQ-016 In GRANT, if the owner's request is high at the edge, cnt SHALL increment by 1 and hcnt SHALL increment by 1.
REQ-017 In GRANT, if hcnt reaches MAX_HOLD through that increment, the FSM SHALL enter GAP and clear gnt on the same edge.
REQ-018 In GRANT, if the owner's request is low at the edge, cnt SHALL NOT change and the FSM SHALL enter GAP with gnt cleared.
REQ-019 Requests from non-owners during GRANT SHALL be ignored and SHALL NOT change cnt, ptr or the tenure.
REQ-020 GAP SHALL last exactly one cycle with gnt=000, so that gnt is never high for two different requesters in consecutive cycles.
REQ-021 cnt SHALL wrap modulo 2^CNT_W (255 -> 0 for CNT_W=8) with no flag and no stall.
REQ-022 gnt SHALL be one-hot or zero at all times; busy SHALL equal |gnt.
REQ-023 A request dropping and rising again within one tenure SHALL NOT extend that tenure; the tenure ends at the first low sample.

Reset
REQ-024 While rst_n=0, the block SHALL force, immediately and independently of clk: state=IDLE, gnt=000, busy=0, cnt=0, ptr=0, hcnt=0.
REQ-025 An assertion of rst_n in mid-tenure SHALL abort the tenure without completing the increment in flight.
REQ-026 After rst_n deasserts, the first grant SHALL follow REQ-013 at the first posedge clk.

Verification (MAX_HOLD=4, CNT_W=8)
REQ-027 Reset check: pulse rst_n=0 between edges during GRANT -> gnt=000, busy=0 and cnt=0 before the next edge; after release with a=1, gnt=001 one edge later.
REQ-028 Single requester: a=1 held, b=c=0 -> gnt=001 for 4 cycles, cnt goes 1,2,3,4; one GAP cycle with gnt=000; then gnt=001 again; cnt=8 after the second tenure.
REQ-029 Round-robin: a=b=c=1 from reset -> grant order 001, 010, 100, 001; cnt=12 after three tenures; every tenure is separated by one gnt=000 cycle.
REQ-030 Early release: b alone, b dropped after 2 granted edges -> cnt+=2, GAP then IDLE; the next request from a or c wins ahead of b (ptr=2).
REQ-031 Wrap: a held for 64 tenures from reset -> cnt=0 after the 256th increment; no glitch on gnt.
REQ-032 Ignore non-owner: owner a granted, c toggles every cycle -> cnt counts only a's high samples; c is granted in the cycle after GAP if a is low.
